// File: rtl/if_id_fetch_ctrl.sv
// Instruction fetch controller with an IF/ID pipeline register and a
// one-entry skid buffer. The skid catches the instruction returned
// while the pipeline is stalled, so no fetched instruction is lost or
// duplicated.
module if_id_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_En,
  input  logic        IFID_ctrl,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [15:0] stall_cnt,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic        stall;
  logic        fire;
  logic [31:0] pc_plus4;

  // Hazard request, handshake and sequential PC (wraps modulo 2^32)
  always_comb begin
    stall    = ~PC_En | ~IFID_ctrl;
    imem_req = (state_q != BOOT) & ~skid_valid_q & ~redirect;
    fire     = imem_req & imem_ready;
    pc_plus4 = pc_q + 32'd4;
  end

  // Next-state logic for the BOOT/RUN/HOLD control FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (stall && !redirect) state_d = HOLD;
      HOLD:    if (!stall || redirect) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // Datapath next values: redirect, then stall, then skid drain, then fetch
  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc4_d    = skid_pc4_q;
    skid_valid_d  = skid_valid_q;
    stall_cnt_d   = stall_cnt_q;

    if (redirect) begin
      // Any instruction returning this cycle belongs to the wrong path
      pc_d          = redirect_pc;
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
      skid_valid_d  = 1'b0;
    end else if (stall) begin
      if (stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
      if (!skid_valid_q && fire) begin
        skid_instr_d = imem_rdata;
        skid_pc4_d   = pc_plus4;
        skid_valid_d = 1'b1;
        pc_d         = pc_plus4;
      end
    end else if (skid_valid_q) begin
      // PC already points past the buffered instruction, so it holds
      if_id_instr_d = skid_instr_q;
      if_id_pc4_d   = skid_pc4_q;
      if_id_valid_d = 1'b1;
      skid_valid_d  = 1'b0;
    end else if (fire) begin
      if_id_instr_d = imem_rdata;
      if_id_pc4_d   = pc_plus4;
      if_id_valid_d = 1'b1;
      pc_d          = pc_plus4;
    end else begin
      if_id_instr_d = NOP_INSTR;
      if_id_valid_d = 1'b0;
    end
  end

  // Architectural state with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc4_q   <= 32'd0;
      if_id_valid_q <= 1'b0;
      skid_valid_q  <= 1'b0;
      stall_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      skid_valid_q  <= skid_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  // Skid payload is qualified by skid_valid_q, so it needs no reset
  always_ff @(posedge clk) begin
    skid_instr_q <= skid_instr_d;
    skid_pc4_q   <= skid_pc4_d;
  end

  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign stall_cnt   = stall_cnt_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_if_id_fetch_ctrl.sv
// Directed testbench for if_id_fetch_ctrl. Instruction memory is a
// combinational model: the word at address A is A ^ KEY.
module tb_if_id_fetch_ctrl;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, PC_En, IFID_ctrl, redirect, imem_ready;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc4;
  logic [15:0] stall_cnt;
  logic [1:0]  fsm_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr ^ KEY;

  if_id_fetch_ctrl dut (
    .clk(clk), .reset(reset), .PC_En(PC_En), .IFID_ctrl(IFID_ctrl),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .stall_cnt(stall_cnt),
    .fsm_state(fsm_state)
  );

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1; PC_En = 1; IFID_ctrl = 1; redirect = 0;
    redirect_pc = 32'h0; imem_ready = 1;
    step(2);
    total++; if (fsm_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", fsm_state); end
    total++; if (imem_addr !== 32'h0040_0000) begin bad++; $display("FAIL rst_addr got=%h exp=00400000", imem_addr); end
    total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || if_id_pc4 !== 32'h0) begin bad++; $display("FAIL rst_ifid got=%b/%h/%h exp=0/%h/0", if_id_valid, if_id_instr, if_id_pc4, NOP); end
    total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", stall_cnt); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
  endtask

  task automatic test_fetch();
    logic [31:0] a;
    reset = 0;
    step(1);
    total++; if (fsm_state !== 2'd1 || imem_addr !== 32'h0040_0000 || if_id_valid !== 1'b0) begin bad++; $display("FAIL boot_exit got=%0d/%h/%b exp=1/00400000/0", fsm_state, imem_addr, if_id_valid); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL run_req got=%b exp=1", imem_req); end
    a = 32'h0040_0000;
    for (int i = 0; i < 3; i++) begin
      step(1);
      total++; if (if_id_instr !== (a ^ KEY) || if_id_pc4 !== a + 32'd4 || if_id_valid !== 1'b1 || imem_addr !== a + 32'd4) begin bad++; $display("FAIL fetch%0d got=%h/%h/%b/%h exp=%h/%h/1/%h", i, if_id_instr, if_id_pc4, if_id_valid, imem_addr, a ^ KEY, a + 32'd4, a + 32'd4); end
      a = a + 32'd4;
    end
  endtask

  task automatic test_stall();
    PC_En = 0; IFID_ctrl = 0;
    step(3);
    total++; if (if_id_instr !== (32'h0040_0008 ^ KEY) || if_id_pc4 !== 32'h0040_000C || if_id_valid !== 1'b1) begin bad++; $display("FAIL stall_hold got=%h/%h/%b exp=%h/0040000c/1", if_id_instr, if_id_pc4, if_id_valid, 32'h0040_0008 ^ KEY); end
    total++; if (imem_addr !== 32'h0040_0010) begin bad++; $display("FAIL stall_pc got=%h exp=00400010", imem_addr); end
    total++; if (stall_cnt !== 16'd3 || fsm_state !== 2'd2) begin bad++; $display("FAIL stall_cnt got=%0d/%0d exp=3/2", stall_cnt, fsm_state); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req got=%b exp=0", imem_req); end
  endtask

  task automatic test_release();
    PC_En = 1; IFID_ctrl = 1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL drain_req got=%b exp=0", imem_req); end
    step(1);
    total++; if (if_id_instr !== (32'h0040_000C ^ KEY) || if_id_pc4 !== 32'h0040_0010 || if_id_valid !== 1'b1 || imem_addr !== 32'h0040_0010 || fsm_state !== 2'd1) begin bad++; $display("FAIL drain got=%h/%h/%b/%h/%0d exp=%h/00400010/1/00400010/1", if_id_instr, if_id_pc4, if_id_valid, imem_addr, fsm_state, 32'h0040_000C ^ KEY); end
    step(1);
    total++; if (if_id_instr !== (32'h0040_0010 ^ KEY) || if_id_pc4 !== 32'h0040_0014 || imem_addr !== 32'h0040_0014) begin bad++; $display("FAIL post_drain got=%h/%h/%h exp=%h/00400014/00400014", if_id_instr, if_id_pc4, imem_addr, 32'h0040_0010 ^ KEY); end
  endtask

  task automatic test_redirect();
    PC_En = 0; IFID_ctrl = 0;
    step(2);
    total++; if (imem_addr !== 32'h0040_0018 || stall_cnt !== 16'd5) begin bad++; $display("FAIL pre_redir got=%h/%0d exp=00400018/5", imem_addr, stall_cnt); end
    redirect = 1; redirect_pc = 32'h0040_0100;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_req got=%b exp=0", imem_req); end
    step(1);
    total++; if (imem_addr !== 32'h0040_0100 || if_id_valid !== 1'b0 || if_id_instr !== NOP || fsm_state !== 2'd1 || stall_cnt !== 16'd5) begin bad++; $display("FAIL redir got=%h/%b/%h/%0d/%0d exp=00400100/0/%h/1/5", imem_addr, if_id_valid, if_id_instr, fsm_state, stall_cnt, NOP); end
    redirect = 0; PC_En = 1; IFID_ctrl = 1;
    #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL redir_skid_clr got=%b exp=1", imem_req); end
    step(1);
    total++; if (if_id_instr !== (32'h0040_0100 ^ KEY) || if_id_valid !== 1'b1 || imem_addr !== 32'h0040_0104) begin bad++; $display("FAIL redir_fetch got=%h/%b/%h exp=%h/1/00400104", if_id_instr, if_id_valid, imem_addr, 32'h0040_0100 ^ KEY); end
  endtask

  task automatic test_bubbles();
    imem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      step(1);
      total++; if (if_id_valid !== 1'b0 || if_id_instr !== NOP || imem_addr !== 32'h0040_0104 || if_id_pc4 !== 32'h0040_0104) begin bad++; $display("FAIL bubble%0d got=%b/%h/%h/%h exp=0/%h/00400104/00400104", i, if_id_valid, if_id_instr, imem_addr, if_id_pc4, NOP); end
    end
    imem_ready = 1;
    step(1);
    total++; if (if_id_instr !== (32'h0040_0104 ^ KEY) || if_id_valid !== 1'b1 || imem_addr !== 32'h0040_0108) begin bad++; $display("FAIL bubble_end got=%h/%b/%h exp=%h/1/00400108", if_id_instr, if_id_valid, imem_addr, 32'h0040_0104 ^ KEY); end
  endtask

  task automatic test_mismatch_saturate();
    PC_En = 1; IFID_ctrl = 0;
    step(1);
    total++; if (stall_cnt !== 16'd6 || fsm_state !== 2'd2 || if_id_instr !== (32'h0040_0104 ^ KEY) || imem_addr !== 32'h0040_010C) begin bad++; $display("FAIL mismatch got=%0d/%0d/%h/%h exp=6/2/%h/0040010c", stall_cnt, fsm_state, if_id_instr, imem_addr, 32'h0040_0104 ^ KEY); end
    PC_En = 0; IFID_ctrl = 1;
    step(1);
    total++; if (stall_cnt !== 16'd7) begin bad++; $display("FAIL mismatch2 got=%0d exp=7", stall_cnt); end
    step(70000);
    total++; if (stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL saturate got=%h exp=ffff", stall_cnt); end
  endtask

  task automatic test_wrap();
    PC_En = 1; IFID_ctrl = 1; redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect = 0;
    step(1);
    total++; if (if_id_pc4 !== 32'h0 || imem_addr !== 32'h0 || if_id_instr !== (32'hFFFF_FFFC ^ KEY) || stall_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap got=%h/%h/%h/%h exp=0/0/%h/ffff", if_id_pc4, imem_addr, if_id_instr, stall_cnt, 32'hFFFF_FFFC ^ KEY); end
  endtask

  task automatic test_reset_mid();
    PC_En = 0; IFID_ctrl = 0;
    step(1);
    total++; if (imem_req !== 1'b0 || imem_addr !== 32'h4) begin bad++; $display("FAIL mid_skid got=%b/%h exp=0/4", imem_req, imem_addr); end
    reset = 1; redirect = 1; redirect_pc = 32'h1234_0000;
    step(1);
    total++; if (imem_addr !== 32'h0040_0000 || fsm_state !== 2'd0 || stall_cnt !== 16'd0 || if_id_valid !== 1'b0 || if_id_pc4 !== 32'h0) begin bad++; $display("FAIL mid_rst got=%h/%0d/%0d/%b/%h exp=00400000/0/0/0/0", imem_addr, fsm_state, stall_cnt, if_id_valid, if_id_pc4); end
    reset = 0; redirect = 0; PC_En = 1; IFID_ctrl = 1;
    step(1);
    total++; if (imem_req !== 1'b1 || fsm_state !== 2'd1) begin bad++; $display("FAIL mid_skid_gone got=%b/%0d exp=1/1", imem_req, fsm_state); end
    step(1);
    total++; if (if_id_instr !== (32'h0040_0000 ^ KEY) || if_id_pc4 !== 32'h0040_0004 || if_id_valid !== 1'b1) begin bad++; $display("FAIL mid_refetch got=%h/%h/%b exp=%h/00400004/1", if_id_instr, if_id_pc4, if_id_valid, 32'h0040_0000 ^ KEY); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_release();
    test_redirect();
    test_bubbles();
    test_mismatch_saturate();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_ctrl.md
IF_ID_FETCH_CTRL -- requirements
Module: if_id_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0040_0000, which is the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INSTR, default 32'h0000_0000, which is the instruction driven into IF/ID on a bubble or flush.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, the reset; it is synchronous and active-high.
REQ-005 The block SHALL have port PC_En, input, 1 bit; 0 requests a PC hold from the hazard detection unit.
REQ-006 The block SHALL have port IFID_ctrl, input, 1 bit; 0 requests an IF/ID hold from the hazard detection unit.
REQ-007 The block SHALL have port redirect, input, 1 bit, a taken branch or jump resolved downstream.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits, the redirect target address.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits, the instruction returned by instruction memory.
REQ-010 The block SHALL have port imem_ready, input, 1 bit; imem_rdata is valid when imem_req and imem_ready are both 1.
REQ-011 The block SHALL have port imem_req, output, 1 bit, the fetch request.
REQ-012 The block SHALL have port imem_addr, output, 32 bits, the fetch address; it equals the pc register.
REQ-013 The block SHALL have port if_id_instr, output, 32 bits, the instruction in the IF/ID register.
REQ-014 The block SHALL have port if_id_pc4, output, 32 bits, the fetch address of if_id_instr plus 4.
REQ-015 The block SHALL have port if_id_valid, output, 1 bit; 0 marks a bubble.
REQ-016 The block SHALL have port stall_cnt, output, 16 bits, the count of stall cycles.
REQ-017 The block SHALL have port fsm_state, output, 2 bits, encoded BOOT=0, RUN=1, HOLD=2.

Function
REQ-018 The block SHALL compute stall = ~PC_En | ~IFID_ctrl; a mismatch between the two inputs counts as a stall.
REQ-019 Update priority SHALL be reset, then redirect, then stall, then skid drain, then normal fetch.
REQ-020 In BOOT, the block SHALL drive imem_req=0 and SHALL always move to RUN on the next cycle.
REQ-021 From RUN, the block SHALL move to HOLD when stall=1 and redirect=0.
REQ-022 From HOLD, the block SHALL move to RUN when stall=0 or redirect=1.
REQ-023 In RUN and HOLD, the block SHALL drive imem_req = ~skid_valid & ~redirect, combinationally.
REQ-024 The datapath decisions SHALL follow the same-cycle stall input, not the registered state.
REQ-025 On redirect: pc <= redirect_pc, if_id_instr <= NOP_INSTR, if_id_valid <= 0, skid_valid <= 0; any concurrent imem_ready is discarded.
REQ-026 On stall with no redirect: if_id_instr, if_id_pc4 and if_id_valid SHALL hold.
REQ-027 On stall with no redirect, if skid_valid=0 and imem_ready=1: skid <= {imem_rdata, pc+4}, skid_valid <= 1, pc <= pc+4.
REQ-028 On stall with no redirect, if skid_valid=1: pc and skid SHALL hold, and no request is issued.
REQ-029 On skid drain (no stall, skid_valid=1): IF/ID <= skid contents, if_id_valid <= 1, skid_valid <= 0, pc holds.
REQ-030 On normal fetch with imem_ready=1: if_id_instr <= imem_rdata, if_id_pc4 <= pc+4, if_id_valid <= 1, pc <= pc+4.
REQ-031 On normal fetch with imem_ready=0: if_id_instr <= NOP_INSTR, if_id_valid <= 0; if_id_pc4 and pc hold.
REQ-032 pc+4 SHALL be computed modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-033 stall_cnt SHALL increment by 1 each cycle with stall=1 and redirect=0, and SHALL saturate at 16'hFFFF.
REQ-034 At most one instruction SHALL be buffered in the skid; no fetched instruction is lost or duplicated across a stall.

Reset
REQ-035 On reset=1 at a clock edge: pc <= RESET_PC, if_id_instr <= NOP_INSTR, if_id_pc4 <= 0, if_id_valid <= 0, skid_valid <= 0, stall_cnt <= 0, fsm_state <= BOOT.
REQ-036 A reset asserted mid-stall or mid-redirect SHALL override all other inputs, and the skid contents SHALL be discarded.

Verification
REQ-037 Reset, then imem_ready=1 with no stall -> BOOT for 1 cycle; imem_addr sequence 0x00400000, 0x00400004, ...; if_id_pc4 = addr+4, if_id_valid=1.
REQ-038 Stall (PC_En=0, IFID_ctrl=0) for 3 cycles with imem_ready=1 -> IF/ID holds; one instruction enters the skid; pc advances once; stall_cnt=3.
REQ-039 Release from REQ-038 -> skid drains in the first cycle with no request; the next cycle fetches pc; the IF/ID sequence is contiguous.
REQ-040 Redirect to 0x00400100 during a stall with skid_valid=1 -> if_id_valid=0, skid cleared, imem_addr=0x00400100 next cycle, fsm_state=RUN.
REQ-041 imem_ready=0 for 2 cycles with no stall -> two bubbles (if_id_valid=0, instr=NOP_INSTR); pc is unchanged.
REQ-042 Stall held for 70000 cycles -> stall_cnt saturates at 0xFFFF; PC_En=1 with IFID_ctrl=0 -> treated as a stall.
